// File: rtl/match_controller.sv
// Round/match sequencer: countdown, round timer, scoring and best-of-N winner for the game core.
// Optional PAUSE_EN macro adds a PAUSED state toggled by pause_btn during FIGHT.
module match_controller #(
    parameter int unsigned TICK_DIV           = 100_000_000,
    parameter int unsigned ROUND_SECONDS      = 99,
    parameter int unsigned COUNTDOWN_SECONDS  = 3,
    parameter int unsigned ROUND_OVER_SECONDS = 2,
    parameter int unsigned ROUNDS_TO_WIN      = 2,
    parameter int unsigned MAX_ROUNDS         = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [1:0] finish,
    input  logic [3:0] p1_health,
    input  logic [3:0] p2_health,
    output logic       game_reset_n,
    output logic       freeze,
    output logic [2:0] state,
    output logic [2:0] round_num,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [6:0] timer_sec,
    output logic [1:0] countdown,
    output logic [1:0] match_winner
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RW = (ROUND_OVER_SECONDS > 1) ? $clog2(ROUND_OVER_SECONDS) : 1;
    localparam logic [6:0] TIMER_INIT = 7'(ROUND_SECONDS);
    localparam logic [1:0] CD_INIT    = 2'(COUNTDOWN_SECONDS);

`ifdef PAUSE_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, COUNTDOWN = 3'd1, FIGHT = 3'd2,
        ROUND_OVER = 3'd3, MATCH_OVER = 3'd4, PAUSED = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, COUNTDOWN = 3'd1, FIGHT = 3'd2,
        ROUND_OVER = 3'd3, MATCH_OVER = 3'd4
    } state_t;
`endif

    state_t          cur_state, nxt_state;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   ro_cnt, ro_d;
    logic            start_q, start_edge, tick, cnt_hold;
    logic [2:0]      round_d;
    logic [1:0]      p1_d, p2_d, cd_d, win_d;
    logic [6:0]      timer_d;
    logic            grn_d, frz_d;

`ifdef PAUSE_EN
    logic   pause_q, pause_edge;
    state_t saved_state;
    assign pause_edge = pause_btn & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
`endif

    assign start_edge = start_btn & ~start_q;
    assign tick       = (cnt == CW'(TICK_DIV - 1));
    assign state      = cur_state;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state    <= IDLE;
            cnt          <= '0;
            ro_cnt       <= '0;
            start_q      <= 1'b0;
            round_num    <= '0;
            p1_rounds    <= '0;
            p2_rounds    <= '0;
            timer_sec    <= TIMER_INIT;
            countdown    <= '0;
            match_winner <= '0;
            game_reset_n <= 1'b0;
            freeze       <= 1'b1;
`ifdef PAUSE_EN
            pause_q      <= 1'b0;
            saved_state  <= IDLE;
`endif
        end else begin
            cur_state <= nxt_state;
            start_q   <= start_btn;
            // Pause entry/exit keeps the partial second so the round clock resumes where it stopped.
            if (cnt_hold)
                cnt <= cnt;
            else if (nxt_state != cur_state || tick)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            ro_cnt       <= ro_d;
            round_num    <= round_d;
            p1_rounds    <= p1_d;
            p2_rounds    <= p2_d;
            timer_sec    <= timer_d;
            countdown    <= cd_d;
            match_winner <= win_d;
            game_reset_n <= grn_d;
            freeze       <= frz_d;
`ifdef PAUSE_EN
            pause_q <= pause_btn;
            if (nxt_state == PAUSED && cur_state != PAUSED)
                saved_state <= cur_state;
`endif
        end
    end

    always_comb begin
        nxt_state = cur_state;
        round_d   = round_num;
        p1_d      = p1_rounds;
        p2_d      = p2_rounds;
        timer_d   = timer_sec;
        cd_d      = countdown;
        win_d     = match_winner;
        ro_d      = ro_cnt;
        cnt_hold  = 1'b0;
        case (cur_state)
            IDLE, MATCH_OVER: begin
                if (start_edge) begin
                    nxt_state = COUNTDOWN;
                    p1_d      = '0;
                    p2_d      = '0;
                    win_d     = '0;
                    round_d   = 3'd1;
                    timer_d   = TIMER_INIT;
                    cd_d      = CD_INIT;
                end
            end
            COUNTDOWN: begin
                if (tick) begin
                    cd_d = countdown - 2'd1;
                    if (countdown == 2'd1)
                        nxt_state = FIGHT;
                end
            end
            FIGHT: begin
`ifdef PAUSE_EN
                if (pause_edge) begin
                    nxt_state = PAUSED;
                    cnt_hold  = 1'b1;
                end else
`endif
                begin
                    if (tick)
                        timer_d = timer_sec - 7'd1;
                    if (finish[0]) begin
                        nxt_state = ROUND_OVER;
                        ro_d      = '0;
                        if (finish[1]) p2_d = sat_inc(p2_rounds);
                        else           p1_d = sat_inc(p1_rounds);
                    end else if (tick && timer_sec == 7'd1) begin
                        nxt_state = ROUND_OVER;
                        ro_d      = '0;
                        if (p1_health > p2_health)      p1_d = sat_inc(p1_rounds);
                        else if (p2_health > p1_health) p2_d = sat_inc(p2_rounds);
                    end
                end
            end
            ROUND_OVER: begin
                if (tick) begin
                    if (ro_cnt == RW'(ROUND_OVER_SECONDS - 1)) begin
                        ro_d = '0;
                        if (p1_rounds == 2'(ROUNDS_TO_WIN)) begin
                            nxt_state = MATCH_OVER;
                            win_d     = 2'b01;
                        end else if (p2_rounds == 2'(ROUNDS_TO_WIN)) begin
                            nxt_state = MATCH_OVER;
                            win_d     = 2'b11;
                        end else if (round_num == 3'(MAX_ROUNDS)) begin
                            nxt_state = MATCH_OVER;
                            if (p1_rounds > p2_rounds)      win_d = 2'b01;
                            else if (p2_rounds > p1_rounds) win_d = 2'b11;
                            else                            win_d = 2'b10;
                        end else begin
                            nxt_state = COUNTDOWN;
                            round_d   = round_num + 3'd1;
                            timer_d   = TIMER_INIT;
                            cd_d      = CD_INIT;
                        end
                    end else begin
                        ro_d = ro_cnt + RW'(1);
                    end
                end
            end
`ifdef PAUSE_EN
            PAUSED: begin
                cnt_hold = 1'b1;
                if (pause_edge)
                    nxt_state = saved_state;
            end
`endif
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        grn_d = !(nxt_state == IDLE || nxt_state == COUNTDOWN);
        frz_d = (nxt_state != FIGHT);
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Round/match sequencer for the street-fighter game core. It holds the core in reset between rounds and runs the pre-round countdown and the round timer. It scores rounds from the core's finish/health outputs and declares a best-of-N match winner. It sits between the board inputs/VGA top and the game core, and drives the core's active-low reset and a freeze flag that gates player inputs.

Parameters:
TICK_DIV, 100_000_000, clk cycles per one-second tick
ROUND_SECONDS, 99, round timer start value (1..127)
COUNTDOWN_SECONDS, 3, pre-fight countdown length (1..3)
ROUND_OVER_SECONDS, 2, hold time after a round ends
ROUNDS_TO_WIN, 2, round wins needed for the match (1..3)
MAX_ROUNDS, 5, hard cap on rounds per match, draws included (1..7)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_btn  in  1  level; rising edge starts a match
pause_btn  in  1  level; used only with PAUSE_EN
finish  in  2  core game-over code: 00 running, 01 p1 won, 11 p2 won
p1_health  in  4  core health, player 1
p2_health  in  4  core health, player 2
game_reset_n  out  1  active-low reset to game core
freeze  out  1  1 = top masks all player inputs
state  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_OVER, 4 MATCH_OVER, 5 PAUSED
round_num  out  3  current round, 1-based; 0 in IDLE
p1_rounds  out  2  rounds won by p1
p2_rounds  out  2  rounds won by p2
timer_sec  out  7  seconds remaining in round
countdown  out  2  countdown digit, COUNTDOWN_SECONDS..1; 0 elsewhere
match_winner  out  2  00 none, 01 p1, 11 p2, 10 draw

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, game_reset_n=0, freeze=1, round_num=0.
  - p1_rounds=p2_rounds=0, timer_sec=ROUND_SECONDS, countdown=0, match_winner=00.
  - Tick counter=0, button edge registers=0.
- Edge detection:
  - start_btn and pause_btn are registered once; an edge = current & ~prev.
  - Response is one cycle after the input rises.
- Tick:
  - Counter 0..TICK_DIV-1; tick is a one-cycle strobe at TICK_DIV-1.
  - Counter clears on every state change.
  - First tick after entry therefore occurs TICK_DIV cycles later.
- Outputs are registered.
  - game_reset_n=0 in IDLE and COUNTDOWN; 1 otherwise.
  - The full countdown keeps the core's slow position clock in reset long enough to restore spawn positions.
  - freeze=1 in every state except FIGHT.
- IDLE:
  - start edge -> COUNTDOWN.
  - Clears p1_rounds, p2_rounds and match_winner.
  - round_num=1, timer_sec=ROUND_SECONDS, countdown=COUNTDOWN_SECONDS.
- COUNTDOWN:
  - Each tick decrements countdown.
  - A tick with countdown==1 -> FIGHT, countdown=0.
- FIGHT:
  - Each tick decrements timer_sec.
  - Round end, first match wins:
    - a) finish[0]==1: finish==01 -> p1_rounds+1; finish==11 -> p2_rounds+1.
    - b) A tick with timer_sec==1: timer_sec<=0. Higher health scores the round; equal health is a draw (no point).
  - Both (a) and (b) in the same cycle: (a) wins; the timer still shows 0.
  - Round end -> ROUND_OVER.
- ROUND_OVER:
  - The core keeps running with frozen inputs, so the last frame is held.
  - After ROUND_OVER_SECONDS ticks, the first matching rule applies:
    - p1_rounds==ROUNDS_TO_WIN -> MATCH_OVER, winner 01.
    - p2_rounds==ROUNDS_TO_WIN -> MATCH_OVER, winner 11.
    - round_num==MAX_ROUNDS -> MATCH_OVER; the larger round count wins, equal counts give 10.
    - Otherwise round_num+1, timer_sec=ROUND_SECONDS, countdown=COUNTDOWN_SECONDS -> COUNTDOWN.
- MATCH_OVER:
  - Outputs hold.
  - start edge -> same actions as the IDLE start -> COUNTDOWN.
- Other rules:
  - start edges outside IDLE and MATCH_OVER are ignored.
  - Round counters saturate at 3.
  - Reset mid-operation returns to the reset values immediately.

Optional Feature:
- Macro: PAUSE_EN.
- Defined:
  - pause edge in FIGHT -> PAUSED; the state before the pause is saved, the tick counter value is held, freeze=1, game_reset_n=1.
  - pause edge in PAUSED -> back to FIGHT with the tick counter resumed, not cleared.
  - finish is ignored while PAUSED.
  - pause edges in other states are ignored.
- Undefined:
  - pause_btn is ignored; the PAUSED state is unreachable and is never encoded.

Test Plan:
- Setup: TICK_DIV=10, ROUND_SECONDS=5, COUNTDOWN_SECONDS=3, ROUND_OVER_SECONDS=2, ROUNDS_TO_WIN=2.
- Reset then start pulse -> state=1 one cycle later; countdown 3,2,1 at 10-cycle steps; state=2 and game_reset_n=1 at 30 cycles after entry.
- In FIGHT drive finish=01 -> state=3, p1_rounds=1 next cycle; after 20 cycles state=1, round_num=2, timer_sec=5.
- Let the timer expire with p1_health=7, p2_health=9 -> timer_sec=0, p2_rounds+1; repeat with equal health -> no round awarded.
- p2 wins two rounds -> after ROUND_OVER, state=4, match_winner=11; start pulse -> state=1, rounds cleared, round_num=1.
- finish=11 on the same cycle as the final timer tick -> p2 scored, not a health decision; assert reset mid-COUNTDOWN -> state=0, game_reset_n=0 asynchronously.
- (PAUSE_EN) pause at tick counter 4 in FIGHT -> freeze=1, timer_sec constant for 100 cycles; unpause -> next decrement 6 cycles later.
